dec2to4_pol_enc: RTL and testbench
==================================

// Module: dec2to4_pol_enc
// PURPOSE
//  Inverse of the polarity-selectable 2-to-4 decoder: takes the 4-line code D[3:0] and recovers {A2,A1,A0}.
//  A2 is the polarity: A2=1 means active-high one-hot, A2=0 means active-low one-cold.
//  Sits on the receive side of the decoder bus. Inputs use a valid/ready handshake; results are buffered in a small output FIFO.
//  Codes that are not legal are flagged, and optionally dropped.
// PARAMETERS
//  DEPTH         2   output FIFO entries; power of two, >=2
//  DROP_INVALID  0   1: illegal codes are not enqueued (flagged/counted only); 0: enqueued with err=1
//  ERR_CNT_W     8   width of the illegal-code counter (used only with DEC2TO4_POL_ERRCNT_EN)
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous, active-low reset
//  in_valid   in   1          d is valid this cycle
//  in_ready   out  1          block can accept d (= FIFO not full)
//  d          in   4          decoder lines {D3,D2,D1,D0}
//  out_valid  out  1          FIFO head valid
//  out_ready  in   1          consumer takes head
//  a          out  3          recovered {A2,A1,A0}; 3'b000 when err=1
//  err        out  1          head entry was an illegal code
//  err_cnt    out  ERR_CNT_W  saturating illegal-code count (macro only)
// BEHAVIOUR
//  - Legal map, A2=1: d=0010->100, 0001->101, 0100->110, 1000->111.
//  - Legal map, A2=0: d=1101->000, 1110->001, 1011->010, 0111->011.
//  - All other 8 d values are illegal.
//  - Accept when in_valid && in_ready. The result is written to the FIFO on that clock edge.
//  - out_valid rises the next cycle when the FIFO was empty, so latency is 1 cycle. There is no combinational in->out path.
//  - Pop when out_valid && out_ready.
//  - in_ready = !full, registered from the occupancy count.
//  - Push and pop in the same cycle while full is NOT allowed: in_ready is already 0 in that cycle.
//  - Push and pop in the same cycle while non-full leaves the count unchanged. Order is strictly FIFO.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
//  - a, err and out_valid must hold stable while out_valid && !out_ready.
//  - When DROP_INVALID=1, an illegal accepted code takes no FIFO slot. in_ready still applies to it.
//  - Reset (async assert, sync release): out_valid=0, in_ready=1 from the first clock after release.
//    Also at reset: a=0, err=0, pointers=0, count=0, err_cnt=0.
//  - Reset asserted mid-operation discards all FIFO contents immediately.
// CONFIGURATION
//  DEC2TO4_POL_ERRCNT_EN defined:
//   - err_cnt increments by 1 on every accepted illegal code, whether or not it is dropped.
//   - It saturates at all-ones, with no wrap.
//  Macro undefined:
//   - The err_cnt port is still present and tied to 0. No counter flops are built.
// STRUCTURE
//  - Package dec2to4_pol_pkg holds:
//    - the 8 legal code localparams;
//    - typedef enc_t {logic err; logic [2:0] a;};
//    - function pol_encode(d) returning enc_t.
//  - Sub-module dec2to4_pol_fifo: a generic DEPTH x WIDTH synchronous FIFO with full/empty.
//  - The top level holds the encode function, the drop logic and the error counter.
// TESTING
//  1 Sweep all 16 d values with out_ready=1 and DROP_INVALID=0.
//    Expect 8 legal codes decoded per the map with err=0. Expect 8 entries with err=1 and a=000.
//  2 d=0010 at cycle 0 -> out_valid=1 with a=100 at cycle 1, not at cycle 0.
//  3 out_ready=0, push 1101 then 0111.
//    Expect in_ready=0 after 2 pushes (DEPTH=2) and the head holding a=000.
//    Then raise out_ready: expect pops 000 then 011 in that order.
//  4 Held at full, drive in_valid=1 with out_ready=1.
//    Expect the new item enqueued on the cycle after the pop and no data lost.
//  5 DROP_INVALID=1 with the macro on: push 0000, 1111, 0011.
//    Expect out_valid to stay 0 and err_cnt=3. Force to near saturation and check it holds at all-ones.
//  6 Fill the FIFO, assert rst_n=0 mid-stream.
//    Expect out_valid=0 at once and, after release, in_ready=1 and the FIFO empty.

Source files
------------

// File: rtl/dec2to4_pol_pkg.sv
// Shared definitions for the polarity-selectable 4-line encoder: legal codes,
// the encoded result type and the code-to-address mapping function.
package dec2to4_pol_pkg;

  // Active-high one-hot codes (A2=1)
  localparam logic [3:0] CODE_H0 = 4'b0010;
  localparam logic [3:0] CODE_H1 = 4'b0001;
  localparam logic [3:0] CODE_H2 = 4'b0100;
  localparam logic [3:0] CODE_H3 = 4'b1000;

  // Active-low one-cold codes (A2=0)
  localparam logic [3:0] CODE_L0 = 4'b1101;
  localparam logic [3:0] CODE_L1 = 4'b1110;
  localparam logic [3:0] CODE_L2 = 4'b1011;
  localparam logic [3:0] CODE_L3 = 4'b0111;

  typedef struct packed {
    logic       err;
    logic [2:0] a;
  } enc_t;

  // Illegal codes report err=1 with a forced to zero so consumers never see junk.
  function automatic enc_t pol_encode(input logic [3:0] d);
    enc_t r;
    r.err = 1'b0;
    r.a   = 3'b000;
    case (d)
      CODE_H0: r.a = 3'b100;
      CODE_H1: r.a = 3'b101;
      CODE_H2: r.a = 3'b110;
      CODE_H3: r.a = 3'b111;
      CODE_L0: r.a = 3'b000;
      CODE_L1: r.a = 3'b001;
      CODE_L2: r.a = 3'b010;
      CODE_L3: r.a = 3'b011;
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dec2to4_pol_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO. Full is registered from the next
// occupancy count so the upstream ready never depends on same-cycle inputs.
module dec2to4_pol_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             full_r;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full_r;
  assign do_pop  = pop && (count != '0);

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage is cleared on reset so the head reads as zero until first write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_r <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count  <= count_next;
      full_r <= (count_next == CW'(DEPTH));
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = full_r;
  assign empty = (count == '0);

endmodule

// File: rtl/dec2to4_pol_enc.sv
// Receive-side encoder: recovers {A2,A1,A0} from decoder lines and buffers results.
// Define DEC2TO4_POL_ERRCNT_EN to build the saturating illegal-code counter.
module dec2to4_pol_enc #(
  parameter int DEPTH        = 2,
  parameter int DROP_INVALID = 0,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           d,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           a,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  import dec2to4_pol_pkg::*;

  enc_t       enc;
  enc_t       head;
  logic [3:0] head_bits;
  logic       accept;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;

  assign enc    = pol_encode(d);
  assign accept = in_valid && in_ready;
  // Dropped illegal codes still need in_ready, they just never take a slot.
  assign push   = accept && !((DROP_INVALID != 0) && enc.err);
  assign pop    = out_valid && out_ready;

  dec2to4_pol_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(enc_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (enc),
    .rdata (head_bits),
    .full  (full),
    .empty (empty)
  );

  assign head      = head_bits;
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign a         = head.a;
  assign err       = head.err;

`ifdef DEC2TO4_POL_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= '0;
    end else if (accept && enc.err && (err_cnt_r != '1)) begin
      err_cnt_r <= err_cnt_r + 1'b1;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_dec2to4_pol_enc.sv
// Directed bench for dec2to4_pol_enc: a keep-invalid instance and a
// drop-invalid instance with a narrow counter to reach saturation quickly.
module tb_dec2to4_pol_enc;

  logic       clk;
  logic       rst_n;

  logic       in_valid;
  logic       in_ready;
  logic [3:0] d;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] a;
  logic       err;
  logic [7:0] err_cnt;

  logic       in_valid1;
  logic       in_ready1;
  logic [3:0] d1;
  logic       out_valid1;
  logic       out_ready1;
  logic [2:0] a1;
  logic       err1;
  logic [2:0] err_cnt1;

  int n_checks;
  int n_fail;

  // Hand-computed {err,a} for d = 0..15
  logic [3:0] sweep_exp [16] = '{
    4'b1000, 4'b0101, 4'b0100, 4'b1000,
    4'b0110, 4'b1000, 4'b1000, 4'b0011,
    4'b0111, 4'b1000, 4'b1000, 4'b0010,
    4'b1000, 4'b0000, 4'b0001, 4'b1000
  };
  logic [3:0] illegal_list [5] = '{4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100};

  dec2to4_pol_enc #(.DEPTH(2), .DROP_INVALID(0), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  dec2to4_pol_enc #(.DEPTH(2), .DROP_INVALID(1), .ERR_CNT_W(3)) dut_drop (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .d         (d1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .a         (a1),
    .err       (err1),
    .err_cnt   (err_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] dd, input logic rdy);
    in_valid  = v;
    d         = dd;
    out_ready = rdy;
  endtask

  task automatic applyDrop(input logic v, input logic [3:0] dd, input logic rdy);
    in_valid1  = v;
    d1         = dd;
    out_ready1 = rdy;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 4'h0, 1'b0);
    applyDrop(1'b0, 4'h0, 1'b0);

    // Reset state
    #2;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_a_err", 32'({err, a}), 32'd0);
    checkOutput("reset_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);

    // Test 1: sweep all codes, consumer always ready
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b1);
      @(negedge clk);
      checkOutput($sformatf("sweep_d%0d", i), 32'({out_valid, err, a}), 32'({1'b1, sweep_exp[i]}));
    end
    applyStimulus(1'b0, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("sweep_drained", 32'(out_valid), 32'd0);
`ifdef DEC2TO4_POL_ERRCNT_EN
    checkOutput("sweep_err_cnt", 32'(err_cnt), 32'd8);
`else
    checkOutput("sweep_err_cnt", 32'(err_cnt), 32'd0);
`endif

    // Test 2: one-cycle latency, no combinational path
    applyStimulus(1'b1, 4'b0010, 1'b0);
    #1;
    checkOutput("latency_cycle0", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("latency_cycle1", 32'({out_valid, err, a}), 32'({1'b1, 1'b0, 3'b100}));
    applyStimulus(1'b0, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("latency_drained", 32'(out_valid), 32'd0);

    // Test 3: fill with out_ready low, then drain in order
    applyStimulus(1'b1, 4'b1101, 1'b0);
    @(negedge clk);
    checkOutput("fill_one_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 4'b0111, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("full_head", 32'({out_valid, err, a}), 32'({1'b1, 1'b0, 3'b000}));
    @(negedge clk);
    checkOutput("stall_hold", 32'({out_valid, err, a}), 32'({1'b1, 1'b0, 3'b000}));
    applyStimulus(1'b0, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("drain_second", 32'({out_valid, err, a}), 32'({1'b1, 1'b0, 3'b011}));
    @(negedge clk);
    checkOutput("drain_empty", 32'({in_ready, out_valid}), 32'({1'b1, 1'b0}));

    // Test 4: input held while full; item enters the cycle after the pop
    applyStimulus(1'b1, 4'b0010, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 4'b0001, 1'b0);
    @(negedge clk);
    checkOutput("t4_full", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 4'b0100, 1'b1);
    @(negedge clk);
    checkOutput("t4_after_pop", 32'({in_ready, out_valid, err, a}), 32'({1'b1, 1'b1, 1'b0, 3'b101}));
    @(negedge clk);
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("t4_new_item", 32'({out_valid, err, a}), 32'({1'b1, 1'b0, 3'b110}));
    @(negedge clk);
    checkOutput("t4_empty", 32'(out_valid), 32'd0);

    // Test 5: drop-invalid instance, counter and saturation
    applyDrop(1'b1, 4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("drop_0000", 32'(out_valid1), 32'd0);
    applyDrop(1'b1, 4'b1111, 1'b1);
    @(negedge clk);
    checkOutput("drop_1111", 32'(out_valid1), 32'd0);
    applyDrop(1'b1, 4'b0011, 1'b1);
    @(negedge clk);
    checkOutput("drop_0011", 32'(out_valid1), 32'd0);
`ifdef DEC2TO4_POL_ERRCNT_EN
    checkOutput("drop_err_cnt3", 32'(err_cnt1), 32'd3);
`else
    checkOutput("drop_err_cnt3", 32'(err_cnt1), 32'd0);
`endif
    applyDrop(1'b1, 4'b0010, 1'b1);
    @(negedge clk);
    checkOutput("drop_legal_passes", 32'({out_valid1, err1, a1}), 32'({1'b1, 1'b0, 3'b100}));
    for (int i = 0; i < 5; i++) begin
      applyDrop(1'b1, illegal_list[i], 1'b1);
      @(negedge clk);
    end
    applyDrop(1'b0, 4'h0, 1'b1);
    checkOutput("drop_still_empty", 32'(out_valid1), 32'd0);
`ifdef DEC2TO4_POL_ERRCNT_EN
    checkOutput("drop_err_cnt_sat", 32'(err_cnt1), 32'd7);
`else
    checkOutput("drop_err_cnt_sat", 32'(err_cnt1), 32'd0);
`endif

    // Test 6: reset mid-stream discards contents
    applyStimulus(1'b1, 4'b1000, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 4'b1110, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("t6_full", 32'({in_ready, out_valid}), 32'({1'b0, 1'b1}));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_reset_a_err", 32'({err, a}), 32'd0);
    checkOutput("t6_reset_err_cnt1", 32'(err_cnt1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t6_release", 32'({in_ready, out_valid}), 32'({1'b1, 1'b0}));
    applyStimulus(1'b0, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("t6_still_empty", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
